// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the RV32I pipeline.
// Holds the EX/MEM pipeline register, runs the data-memory request/ready
// handshake, formats store lanes, extends load data and stalls upstream
// stages while an access is outstanding.
module memory_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_Exec,
    input  logic [31:0] ALU_result_Exec,
    input  logic [31:0] Rdata2_Exec,
    input  logic [4:0]  Rd_Exec,
    input  logic        wrEn_Exec,
    input  logic [6:0]  opcode_Exec,
    input  logic [2:0]  funct3_Exec,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall_Mem,
    output logic [4:0]  Rd_Mem,
    output logic        wrEn_Mem,
    output logic [6:0]  opcode_Mem,
    output logic [31:0] ALU_output_Mem,
    output logic        mem_wEn_Mem,
    output logic [31:0] Data_mem_Mem,
    output logic        misaligned_Mem
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  rd_q;
    logic        wren_q;
    logic [6:0]  opcode_q;
    logic [31:0] alu_q;
    logic [31:0] store_data_q;
    logic [2:0]  funct3_q;
    logic [31:0] load_data_q;

    logic        exec_mem_op;
    logic        exec_aligned_mem;
    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [31:0] lane_word;
    logic [31:0] load_ext;

    // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        logic result;
        result = 1'b0;
        case (size)
            2'b01:   result = addr[0];
            2'b10:   result = (addr != 2'b00);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    // Classify the instruction currently offered by EX.
    always_comb begin
        exec_mem_op      = valid_Exec && ((opcode_Exec == OP_LOAD) || (opcode_Exec == OP_STORE));
        exec_aligned_mem = exec_mem_op && !is_misaligned(funct3_Exec[1:0], ALU_result_Exec[1:0]);
    end

    // EX/MEM pipeline register; frozen while an access is outstanding.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q         <= '0;
            wren_q       <= 1'b0;
            opcode_q     <= '0;
            alu_q        <= '0;
            store_data_q <= '0;
            funct3_q     <= '0;
        end else if (state != BUSY) begin
            rd_q         <= Rd_Exec;
            wren_q       <= valid_Exec && wrEn_Exec;
            opcode_q     <= valid_Exec ? opcode_Exec : 7'd0;
            alu_q        <= ALU_result_Exec;
            store_data_q <= Rdata2_Exec;
            funct3_q     <= funct3_Exec;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: BUSY waits for ready; IDLE and DONE are capture cycles.
    always_comb begin
        state_next = state;
        case (state)
            BUSY:    state_next = dmem_ready ? DONE : BUSY;
            default: state_next = exec_aligned_mem ? BUSY : IDLE;
        endcase
    end

    // Load result register; updated only when a load completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            load_data_q <= '0;
        end else if ((state == BUSY) && dmem_ready && is_load) begin
            load_data_q <= load_ext;
        end
    end

    // Decode of the held instruction, store lane placement and load extension.
    always_comb begin
        is_load     = (opcode_q == OP_LOAD);
        is_store    = (opcode_q == OP_STORE);
        misaligned  = (is_load || is_store) && is_misaligned(funct3_q[1:0], alu_q[1:0]);

        store_be    = 4'b1111;
        store_wdata = store_data_q;
        case (funct3_q[1:0])
            2'b00: begin
                store_be    = 4'b0001 << alu_q[1:0];
                store_wdata = {4{store_data_q[7:0]}};
            end
            2'b01: begin
                store_be    = 4'b0011 << {alu_q[1], 1'b0};
                store_wdata = {2{store_data_q[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = store_data_q;
            end
        endcase

        lane_word = dmem_rdata >> {alu_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b100:  load_ext = {24'd0, lane_word[7:0]};
            3'b101:  load_ext = {16'd0, lane_word[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    // FSM outputs and published MEM-stage signals; memory port is quiet outside BUSY.
    always_comb begin
        dmem_req       = (state == BUSY);
        stall_Mem      = (state == BUSY);
        dmem_we        = dmem_req && is_store;
        dmem_addr      = dmem_req ? {alu_q[31:2], 2'b00} : '0;
        dmem_be        = dmem_req ? (is_store ? store_be : 4'b1111) : '0;
        dmem_wdata     = (dmem_req && is_store) ? store_wdata : '0;
        mem_wEn_Mem    = is_store && (state != IDLE);
        misaligned_Mem = misaligned;
        Rd_Mem         = rd_q;
        wrEn_Mem       = wren_q && !misaligned;
        opcode_Mem     = opcode_q;
        ALU_output_Mem = alu_q;
        Data_mem_Mem   = load_data_q;
    end

endmodule
